// File: rtl/clock_period_monitor.sv
// clock_period_monitor
// Measures the half-period of an asynchronous periodic input in system clock
// cycles. Reports each measurement, flags short/long half-periods and stuck
// input, and asserts lock after LOCK_COUNT consecutive in-range measurements.
module clock_period_monitor #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mon_in,
  input  logic [CNT_WIDTH-1:0] min_half,
  input  logic [CNT_WIDTH-1:0] max_half,
  input  logic                 clear_errors,
  output logic [CNT_WIDTH-1:0] half_period,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 too_short,
  output logic                 too_long,
  output logic                 stuck,
  output logic [CNT_WIDTH-1:0] edge_count
);

  localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StMeasure
  } state_e;

  // Input synchronizer: sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (history)
  logic [2:0] sync_q;
  logic       edge_det;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
  logic [LockW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   locked_q, locked_d;
  logic                   stuck_q, stuck_d;
  logic                   too_short_q, too_short_d;
  logic                   too_long_q, too_long_d;
  logic [CNT_WIDTH-1:0]   half_period_q, half_period_d;
  logic                   meas_valid_q, meas_valid_d;

  // Helper values for the next-state logic
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [LockW-1:0]       lock_inc;
  logic                   set_short;
  logic                   set_long;

  // Synchronize mon_in into the clock domain and keep one cycle of history
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], mon_in};
    end
  end

  // Either polarity of transition counts as an edge
  assign edge_det = sync_q[1] ^ sync_q[2];

  // Saturating increments: the elapsed counter never wraps
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign lock_inc = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + 1'b1;

  // State and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      edge_cnt_q    <= '0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      stuck_q       <= 1'b0;
      too_short_q   <= 1'b0;
      too_long_q    <= 1'b0;
      half_period_q <= '0;
      meas_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      stuck_q       <= stuck_d;
      too_short_q   <= too_short_d;
      too_long_q    <= too_long_d;
      half_period_q <= half_period_d;
      meas_valid_q  <= meas_valid_d;
    end
  end

  // Next-state, measurement, range check and timeout logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    edge_cnt_d    = edge_cnt_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    stuck_d       = stuck_q;
    half_period_d = half_period_q;
    meas_valid_d  = 1'b0;
    set_short     = 1'b0;
    set_long      = 1'b0;

    if (!enable) begin
      // Dropping enable wins over any simultaneous edge
      state_d    = StIdle;
      cnt_d      = '0;
      edge_cnt_d = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      stuck_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          stuck_d    = 1'b0;
          state_d    = StAcquire;
        end

        StAcquire: begin
          // First edge only starts the timing; nothing is measured
          if (edge_det) begin
            state_d    = StMeasure;
            cnt_d      = CntOne;
            edge_cnt_d = CntOne;
          end
        end

        StMeasure: begin
          if (edge_det) begin
            half_period_d = cnt_q;
            meas_valid_d  = 1'b1;
            edge_cnt_d    = edge_cnt_q + 1'b1;
            cnt_d         = CntOne;
            stuck_d       = 1'b0;
            if (cnt_q < min_half) begin
              set_short  = 1'b1;
              lock_cnt_d = '0;
              locked_d   = 1'b0;
            end else if (cnt_q > max_half) begin
              set_long   = 1'b1;
              lock_cnt_d = '0;
              locked_d   = 1'b0;
            end else begin
              lock_cnt_d = lock_inc;
              locked_d   = (lock_inc == LockMax);
            end
          end else begin
            cnt_d = cnt_inc;
            // Elapsed count already beyond max_half with no edge: input is stuck
            if (cnt_q > max_half) begin
              stuck_d    = 1'b1;
              set_long   = 1'b1;
              lock_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // A new error in the same cycle as clear_errors keeps the flag set
    too_short_d = set_short | (too_short_q & ~clear_errors);
    too_long_d  = set_long | (too_long_q & ~clear_errors);
  end

  assign half_period = half_period_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign too_short   = too_short_q;
  assign too_long    = too_long_q;
  assign stuck       = stuck_q;
  assign edge_count  = edge_cnt_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed testbench for clock_period_monitor with hand-computed expectations.
// mon_in is toggled a whole number of clock cycles apart, so each measured
// half-period equals the number of cycles between two toggles.
module tb_clock_period_monitor;

  localparam int unsigned W = 16;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         mon_in;
  logic [W-1:0] min_half;
  logic [W-1:0] max_half;
  logic         clear_errors;
  logic [W-1:0] half_period;
  logic         meas_valid;
  logic         locked;
  logic         too_short;
  logic         too_long;
  logic         stuck;
  logic [W-1:0] edge_count;

  int checks = 0;
  int errors = 0;
  int mv;
  logic [W-1:0] hp;

  clock_period_monitor #(
    .CNT_WIDTH (W),
    .LOCK_COUNT(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mon_in      (mon_in),
    .min_half    (min_half),
    .max_half    (max_half),
    .clear_errors(clear_errors),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .too_short   (too_short),
    .too_long    (too_long),
    .stuck       (stuck),
    .edge_count  (edge_count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Toggle mon_in, then run n cycles counting meas_valid pulses; optional
  // clear_errors pulse sampled at cycle clr_tick of the window (0 = none).
  task automatic period(input int n, input int clr_tick);
    mon_in = ~mon_in;
    mv = 0;
    for (int i = 1; i <= n; i++) begin
      clear_errors = (i == clr_tick);
      tick();
      clear_errors = 1'b0;
      if (meas_valid === 1'b1) begin
        mv++;
        hp = half_period;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    mon_in       = 1'b0;
    min_half     = W'(4);
    max_half     = W'(6);
    clear_errors = 1'b0;
    mv           = 0;
    hp           = '0;
    tick();
    tick();

    // Reset state
    check("rst_half_period", 32'(half_period), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_flags", 32'({too_short, too_long, stuck}), 0);
    check("rst_edge_count", 32'(edge_count), 0);

    reset  = 1'b0;
    enable = 1'b1;
    tick();
    tick();

    // Nominal: acquire edge then four 5-cycle half-periods
    period(5, 0);
    check("acq_no_meas", 32'(mv), 0);
    check("acq_edge_count", 32'(edge_count), 1);
    for (int k = 1; k <= 4; k++) begin
      period(5, 0);
      check("nom_meas_valid", 32'(mv), 1);
      check("nom_half_period", 32'(hp), 5);
      if (k == 3) check("nom_not_locked_3", 32'(locked), 0);
    end
    check("nom_locked_4", 32'(locked), 1);
    check("nom_no_errors", 32'({too_short, too_long, stuck}), 0);
    check("nom_edge_count", 32'(edge_count), 5);

    // Short glitch: one 2-cycle half-period
    period(2, 0);
    check("glitch_window_pulses", 32'(mv), 0);
    period(5, 0);
    check("glitch_pulses", 32'(mv), 2);
    check("glitch_half_period", 32'(hp), 2);
    check("glitch_too_short", 32'(too_short), 1);
    check("glitch_unlocked", 32'(locked), 0);
    for (int k = 1; k <= 4; k++) begin
      period(5, 0);
      if (k == 3) check("relock_not_yet", 32'(locked), 0);
    end
    check("relock_locked", 32'(locked), 1);
    check("relock_short_sticky", 32'(too_short), 1);
    period(5, 4);
    check("clear_too_short", 32'(too_short), 0);
    check("clear_still_locked", 32'(locked), 1);
    check("edge_count_12", 32'(edge_count), 12);

    // Stuck input: no toggle; timeout registers 7 cycles after the last edge
    for (int k = 0; k < 4; k++) tick();
    check("stuck_not_yet", 32'(stuck), 0);
    check("stuck_locked_before", 32'(locked), 1);
    tick();
    check("stuck_set", 32'(stuck), 1);
    check("stuck_too_long", 32'(too_long), 1);
    check("stuck_unlocked", 32'(locked), 0);
    tick();
    tick();
    period(5, 0);
    check("stuck_meas_valid", 32'(mv), 1);
    check("stuck_gap", 32'(hp), 12);
    check("stuck_cleared", 32'(stuck), 0);
    check("stuck_too_long_kept", 32'(too_long), 1);

    // Clear collision: clear_errors in the same cycle as a D = 9 measurement
    period(5, 5);
    check("clear_too_long", 32'(too_long), 0);
    max_half = W'(8);
    period(9, 0);
    check("pre_collision_too_long", 32'(too_long), 0);
    check("pre_collision_stuck", 32'(stuck), 0);
    period(5, 3);
    check("collision_half_period", 32'(hp), 9);
    check("collision_too_long", 32'(too_long), 1);
    max_half = W'(6);

    // Reset mid-measurement, three cycles after an edge
    period(5, 0);
    period(3, 0);
    reset = 1'b1;
    tick();
    check("mid_rst_half_period", 32'(half_period), 0);
    check("mid_rst_flags", 32'({meas_valid, locked, too_short, too_long, stuck}), 0);
    check("mid_rst_edge_count", 32'(edge_count), 0);
    reset = 1'b0;
    tick();
    tick();
    period(6, 0);
    check("post_rst_first_edge", 32'(mv), 0);
    check("post_rst_edge_count", 32'(edge_count), 1);
    period(5, 0);
    check("post_rst_meas", 32'(mv), 1);
    check("post_rst_half_period", 32'(hp), 6);
    period(5, 0);
    period(5, 0);
    check("post_rst_not_locked", 32'(locked), 0);
    period(5, 0);
    check("post_rst_locked", 32'(locked), 1);
    check("post_rst_too_long", 32'(too_long), 0);

    // Enable drop while locked
    enable = 1'b0;
    tick();
    check("drop_locked", 32'(locked), 0);
    check("drop_edge_count", 32'(edge_count), 0);
    check("drop_half_period_held", 32'(half_period), 5);
    enable = 1'b1;
    period(5, 0);
    check("reacq_no_meas", 32'(mv), 0);
    check("reacq_edge_count", 32'(edge_count), 1);
    period(5, 0);
    check("reacq_meas", 32'(mv), 1);
    check("reacq_half_period", 32'(hp), 5);

    // Minimum resolvable half-period of one cycle
    period(1, 0);
    check("d1_window_pulses", 32'(mv), 0);
    period(5, 0);
    check("d1_pulses", 32'(mv), 2);
    check("d1_half_period", 32'(hp), 1);
    check("d1_too_short", 32'(too_short), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_period_monitor.md
# clock_period_monitor

Synchronous checker that observes an externally generated periodic signal, such as a stimulus clock or a divided clock, and measures its half-period in system `clock` cycles. It flags half-periods that are too short or too long, detects a stuck input, and reports lock once the signal is stable. It is the consuming end of a clock source: it sits beside the processor core and the testbench clock source and is readable as plain status outputs.

## Interface
- `CNT_WIDTH`, 16: width of the half-period counter, the limits, and the measurement outputs.
- `LOCK_COUNT`, 4: number of consecutive in-range measurements required before `locked` asserts (1..15).
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `enable` in 1: 1 = monitor runs; 0 = return to IDLE.
- `mon_in` in 1: monitored signal, asynchronous to `clock`.
- `min_half` in CNT_WIDTH: smallest legal half-period, in clock cycles.
- `max_half` in CNT_WIDTH: largest legal half-period, in clock cycles; requires `min_half` ≤ `max_half`.
- `clear_errors` in 1: clears the sticky error flags.
- `half_period` out CNT_WIDTH: last measured half-period.
- `meas_valid` out 1: one-cycle pulse when `half_period` updates.
- `locked` out 1: signal is stable and in range.
- `too_short` out 1: sticky; a half-period below `min_half` was seen.
- `too_long` out 1: sticky; a half-period or timeout above `max_half` was seen.
- `stuck` out 1: live flag; no edge for more than `max_half` cycles.
- `edge_count` out CNT_WIDTH: number of edges detected since leaving IDLE; wraps modulo 2^CNT_WIDTH.

## Operation
- Input path:
  - `mon_in` passes through a 2-flop synchronizer (s1, s2) and a history flop s3.
  - An edge is detected when s2 ≠ s3. Rising and falling edges are treated identically.
- State machine states: IDLE, ACQUIRE, MEASURE.
  - IDLE → ACQUIRE when `enable` = 1.
  - ACQUIRE → MEASURE on the first detected edge. This edge starts timing and produces no measurement. `edge_count` becomes 1.
  - Any state → IDLE when `enable` = 0. In IDLE, the counter, `edge_count`, lock counter, `locked` and `stuck` are all 0. The sticky flags and `half_period` hold their values.
- Measurement:
  - D is the number of clock cycles between two consecutive edge-detect cycles.
  - On each edge in MEASURE: `half_period` ← D, `meas_valid` = 1 for one cycle, and `edge_count` increments.
  - The internal counter saturates at 2^CNT_WIDTH−1. It never wraps.
- Range check on each measurement:
  - D < `min_half`: set `too_short`, clear the lock counter, `locked` = 0.
  - D > `max_half`: set `too_long`, clear the lock counter, `locked` = 0.
  - Otherwise: increment the lock counter, saturating at `LOCK_COUNT`. `locked` = 1 when the counter equals `LOCK_COUNT`.
- Timeout:
  - In MEASURE, when the elapsed count since the last edge reaches `max_half`+1, set `stuck` and `too_long`, clear the lock counter, and set `locked` = 0.
  - `stuck` clears on the next detected edge.
  - The measurement taken at that edge is still reported and also flags `too_long`.
- `clear_errors`:
  - Clears `too_short` and `too_long` on the next edge.
  - If a new error is detected in the same cycle, the error wins and the flag stays 1.
- `reset`:
  - Outputs go to `half_period` = 0, `meas_valid` = 0, `locked` = 0, `too_short` = 0, `too_long` = 0, `stuck` = 0, `edge_count` = 0.
  - State goes to IDLE; synchronizer flops go to 0.
  - `reset` overrides `enable` and any operation in progress. Mid-measurement, the partial count is discarded.

## Timing
- Edge-to-output latency: a level change of `mon_in` first sampled at clock edge k causes `meas_valid`/`half_period` to update at edge k+2.
- All outputs are registered, with no combinational path from inputs.
- The minimum resolvable half-period is 1 cycle; D = 1 is measured correctly.
- The limits `min_half`/`max_half` are sampled every cycle; changing them mid-measurement applies from the next comparison.
- `enable` deassertion takes effect at the next edge. A simultaneous edge on `mon_in` is ignored.

## Test plan
- Nominal:
  - Stimulus: clock period 20, `mon_in` toggling every 100 time units, `min_half` = 4, `max_half` = 6.
  - Response: every measurement gives `half_period` = 5 with a `meas_valid` pulse. `locked` rises on the 4th measurement and no error flags are set.
- Short glitch:
  - Stimulus: after lock, one half-period of 2 cycles.
  - Response: `too_short` = 1 and `locked` = 0. Four subsequent good periods relock; `too_short` stays 1 until `clear_errors`.
- Stuck input:
  - Stimulus: after lock, hold `mon_in` constant.
  - Response: 7 cycles after the last edge, `stuck` = 1, `too_long` = 1, `locked` = 0. On the next toggle, `stuck` = 0 and `half_period` equals the gap.
- Clear collision:
  - Stimulus: `clear_errors` = 1 in the same cycle as a D = 9 measurement.
  - Response: `too_long` remains 1.
- Reset mid-measurement:
  - Stimulus: `reset` asserted 3 cycles after an edge.
  - Response: all outputs are 0 the next cycle. After release, the first edge produces no `meas_valid` and the second edge reports the correct D.
- Enable drop:
  - Stimulus: `enable` = 0 while locked.
  - Response: `locked` = 0 and `edge_count` = 0 next cycle; `half_period` holds. Re-enabling requires a new acquire.
